grid_slot_nway: RTL and testbench
=================================

# grid_slot_nway

Parametrised reconfigurable compute slot for the RCA grid: N operand channels, each buffered in its own FIFO, joined when every enabled channel holds data, then processed by a runtime-selected operation into a single-entry registered output with ready/valid backpressure. Sits in the same grid position as the two-input load slot. It adds channel-count, width and depth parameters, a runtime config port, downstream backpressure, flush, and per-channel overflow reporting.

## Interface
- NUM_INPUTS, 3, operand channel count (>= 2)
- DATA_WIDTH, XLEN, operand/result width
- FIFO_DEPTH, MAX_IDS, entries per channel FIFO (power of two, >= 2)
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- data_in  in  NUM_INPUTS x DATA_WIDTH  per-channel operand
- data_valid_in  in  NUM_INPUTS  per-channel push strobe
- data_out  out  DATA_WIDTH  result register
- data_valid_out  out  1  result register occupied
- data_ready_in  in  1  downstream accepts result this cycle
- cfg_valid  in  1  reconfiguration request; held until cfg_ack
- cfg_op  in  3  slot_op_t operation
- cfg_use_mask  in  NUM_INPUTS  channels participating in join
- cfg_use_const  in  1  operand B is cfg_const instead of channel 1
- cfg_const  in  DATA_WIDTH  constant operand
- cfg_ack  out  1  one-cycle pulse: config latched
- flush  in  1  discard all buffered operands and result
- fifo_level  out  NUM_INPUTS x clog2(FIFO_DEPTH+1)  per-channel occupancy
- overflow  out  NUM_INPUTS  sticky: push dropped on full channel

## Operation
- Push: channel i writes when data_valid_in[i] && use_mask[i]. Unused channels ignore pushes, no error. Push to a full FIFO succeeds only if that FIFO pops the same cycle; otherwise data is dropped and overflow[i] is set.
- Join/fire: all enabled FIFOs are non-empty, use_mask != 0, and (!data_valid_out || data_ready_in). Fire pops every enabled FIFO and loads the output register.
- A = channel 0 head; B = cfg_use_const ? const : channel 1 head.
- Ops (slot_op_t): PASS=A, ADD=A+B, SUB=A-B, AND, OR, XOR, SLL=A<<B[clog2(DATA_WIDTH)-1:0], SUM = sum of all enabled channel heads.
- All arithmetic wraps modulo 2^DATA_WIDTH. Channel 1 is not required in the mask when cfg_use_const=1.
- Output: data_valid_out clears on data_ready_in without a same-cycle fire. Simultaneous ready and fire replaces the result; valid stays 1.
- Config: accepted only when idle, i.e. all FIFOs empty, !data_valid_out, no fire. Config is latched at the edge where cfg_valid && idle. cfg_ack pulses the following cycle. Requester holds cfg_valid until ack; pushes during a pending request are still accepted and delay acceptance.
- Flush: clears all FIFOs, the output register, and overflow in one edge. It has priority over same-cycle push, fire and config acceptance. Config is retained.
- Reset values: FIFOs empty, fifo_level=0, data_valid_out=0, data_out=0, overflow=0, cfg_ack=0. Config resets to op=PASS, mask=0, const=0 (slot inert until configured).

## Timing
- Push at edge N: fifo_level updates and head is visible after N. Earliest fire at edge N+1; data_valid_out=1 after N+1. Minimum push-to-result latency is 2 cycles.
- Throughput: 1 result/cycle when data_ready_in is held high and operands stream.
- Backpressure: with data_ready_in=0 and output full, no fire. FIFOs fill to FIFO_DEPTH, then overflow.
- fifo_level is registered and reflects post-edge occupancy. Simultaneous push and pop leaves the level unchanged, including at full and empty.
- Reset asserted mid-operation takes effect at the next edge, identical to flush plus config reset. A pending cfg_valid must be reissued.

## Structure
- rca_config package: slot_op_t (3-bit enum), GRID_SLOT_DEFAULT_DEPTH.
- Sub-module grid_slot_alu: combinational, op select + operand vector to result. Per-channel FIFOs are inline circular buffers with level counters, so there is no dependency on the shared FIFO interface.

## Test plan
- Mask=3'b011, op=ADD, push 5 on ch0 at cycle 0 and 7 on ch1 at cycle 3, ready=1 -> data_out=12, valid at cycle 5, one result.
- Mask=3'b111, op=SUM, push 0xFFFFFFFF,1,2 -> data_out=0x00000002 (wrap).
- Ready=0, push FIFO_DEPTH+1 values on ch0 and ch1 -> ch0 and ch1 levels=FIFO_DEPTH, overflow=3'b011, output holds the first result; ready=1 -> drained in order, no lost entries except the dropped one.
- Mask=3'b001, use_const=1, const=4, op=SLL, push 1 -> data_out=16; pushes on ch1 ignored, overflow stays 0.
- cfg_valid while ch0 holds data -> no ack until drained; ack the cycle after idle; flush with cfg pending -> levels 0, ack the following cycle.
- rst asserted with full FIFOs and valid output -> all outputs at reset values next cycle; pushes with mask=0 ignored.

Source files
------------

// File: rtl/grid_slot_nway_pkg.sv
// Shared slot definitions: operation encoding and default sizing for grid compute slots.
// No logic; imported by every file of the slot.
package grid_slot_nway_pkg;

   localparam int XLEN                    = 32;
   localparam int GRID_SLOT_DEFAULT_DEPTH = 4;
   localparam int MAX_IDS                 = GRID_SLOT_DEFAULT_DEPTH;

   typedef enum logic [2:0] {
      OP_PASS = 3'd0,
      OP_ADD  = 3'd1,
      OP_SUB  = 3'd2,
      OP_AND  = 3'd3,
      OP_OR   = 3'd4,
      OP_XOR  = 3'd5,
      OP_SLL  = 3'd6,
      OP_SUM  = 3'd7
   } slot_op_t;

endpackage

// File: rtl/grid_slot_nway_if.sv
// Operand/result bus of the compute slot: per-channel push strobes in, one
// registered result out with valid/ready. The slot side uses the slave modport.
interface grid_slot_nway_if #(
   parameter int NUM_INPUTS = 3,
   parameter int DATA_WIDTH = 32
);
   logic [NUM_INPUTS-1:0][DATA_WIDTH-1:0] data_in;
   logic [NUM_INPUTS-1:0]                 data_valid_in;
   logic [DATA_WIDTH-1:0]                 data_out;
   logic                                  data_valid_out;
   logic                                  data_ready_in;

   modport master (
      output data_in, data_valid_in, data_ready_in,
      input  data_out, data_valid_out
   );

   modport slave (
      input  data_in, data_valid_in, data_ready_in,
      output data_out, data_valid_out
   );
endinterface

// File: rtl/grid_slot_alu.sv
// Combinational operation select over the channel FIFO heads; zero latency.
// No flow control of its own: the caller decides when the result is captured.
module grid_slot_alu
   import grid_slot_nway_pkg::*;
#(
   parameter int NUM_INPUTS = 3,
   parameter int DATA_WIDTH = XLEN
) (
   input  slot_op_t                              op,
   input  logic [NUM_INPUTS-1:0]                 use_mask,
   input  logic                                  use_const,
   input  logic [DATA_WIDTH-1:0]                 cst,
   input  logic [NUM_INPUTS-1:0][DATA_WIDTH-1:0] heads,
   output logic [DATA_WIDTH-1:0]                 result
);
   localparam int SHW = $clog2(DATA_WIDTH);

   logic [DATA_WIDTH-1:0] a;
   logic [DATA_WIDTH-1:0] b;
   logic [DATA_WIDTH-1:0] sum;

   always_comb begin
      a   = heads[0];
      b   = use_const ? cst : heads[1];
      sum = '0;
      for (int i = 0; i < NUM_INPUTS; i++) begin
         if (use_mask[i]) sum = sum + heads[i];
      end
      case (op)
         OP_PASS: result = a;
         OP_ADD:  result = a + b;
         OP_SUB:  result = a - b;
         OP_AND:  result = a & b;
         OP_OR:   result = a | b;
         OP_XOR:  result = a ^ b;
         OP_SLL:  result = a << b[SHW-1:0];
         OP_SUM:  result = sum;
         default: result = a;
      endcase
   end
endmodule

// File: rtl/grid_slot_nway.sv
// N-channel compute slot: per-channel FIFOs joined, one op, registered result; push-to-result 2 cycles.
// Fires only when the result register is free or drained this cycle; pushes to a full channel are dropped and flagged.
module grid_slot_nway
   import grid_slot_nway_pkg::*;
#(
   parameter int NUM_INPUTS = 3,
   parameter int DATA_WIDTH = XLEN,
   parameter int FIFO_DEPTH = MAX_IDS,
   localparam int LVL_W     = $clog2(FIFO_DEPTH + 1),
   localparam int PTR_W     = $clog2(FIFO_DEPTH)
) (
   input  logic                             clk,
   input  logic                             rst,
   grid_slot_nway_if.slave                  slot,
   input  logic                             cfg_valid,
   input  logic [2:0]                       cfg_op,
   input  logic [NUM_INPUTS-1:0]            cfg_use_mask,
   input  logic                             cfg_use_const,
   input  logic [DATA_WIDTH-1:0]            cfg_const,
   output logic                             cfg_ack,
   input  logic                             flush,
   output logic [NUM_INPUTS-1:0][LVL_W-1:0] fifo_level,
   output logic [NUM_INPUTS-1:0]            overflow
);
   slot_op_t              op_q;
   logic [NUM_INPUTS-1:0] mask_q;
   logic                  use_const_q;
   logic [DATA_WIDTH-1:0] const_q;

   logic [DATA_WIDTH-1:0] mem    [NUM_INPUTS][FIFO_DEPTH];
   logic [PTR_W-1:0]      rd_ptr [NUM_INPUTS];
   logic [PTR_W-1:0]      wr_ptr [NUM_INPUTS];

   logic [NUM_INPUTS-1:0][DATA_WIDTH-1:0] heads;
   logic [NUM_INPUTS-1:0] push, pop, ovf_set;
   logic [DATA_WIDTH-1:0] result;
   logic join_ok, fire, idle, cfg_accept;

   always_comb begin
      join_ok = (mask_q != '0);
      idle    = !slot.data_valid_out;
      for (int i = 0; i < NUM_INPUTS; i++) begin
         heads[i] = mem[i][rd_ptr[i]];
         if (mask_q[i] && fifo_level[i] == '0) join_ok = 1'b0;
         if (fifo_level[i] != '0) idle = 1'b0;
      end
      fire = join_ok && (!slot.data_valid_out || slot.data_ready_in);
      if (fire) idle = 1'b0;
      // A full channel can still accept when it pops in the same cycle.
      for (int i = 0; i < NUM_INPUTS; i++) begin
         pop[i]     = fire && mask_q[i];
         push[i]    = slot.data_valid_in[i] && mask_q[i] &&
                      (fifo_level[i] != LVL_W'(FIFO_DEPTH) || pop[i]);
         ovf_set[i] = slot.data_valid_in[i] && mask_q[i] &&
                      fifo_level[i] == LVL_W'(FIFO_DEPTH) && !pop[i];
      end
      cfg_accept = cfg_valid && idle && !flush && !rst;
   end

   grid_slot_alu #(
      .NUM_INPUTS (NUM_INPUTS),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_alu (
      .op        (op_q),
      .use_mask  (mask_q),
      .use_const (use_const_q),
      .cst       (const_q),
      .heads     (heads),
      .result    (result)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         op_q        <= OP_PASS;
         mask_q      <= '0;
         use_const_q <= 1'b0;
         const_q     <= '0;
      end else if (cfg_accept) begin
         op_q        <= slot_op_t'(cfg_op);
         mask_q      <= cfg_use_mask;
         use_const_q <= cfg_use_const;
         const_q     <= cfg_const;
      end
      cfg_ack <= cfg_accept;
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_INPUTS; i++) begin
         if (push[i]) mem[i][wr_ptr[i]] <= slot.data_in[i];
      end
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         for (int i = 0; i < NUM_INPUTS; i++) begin
            rd_ptr[i] <= '0;
            wr_ptr[i] <= '0;
         end
         fifo_level          <= '0;
         overflow            <= '0;
         slot.data_valid_out <= 1'b0;
         slot.data_out       <= '0;
      end else begin
         for (int i = 0; i < NUM_INPUTS; i++) begin
            if (push[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
            if (pop[i])  rd_ptr[i] <= rd_ptr[i] + 1'b1;
            fifo_level[i] <= fifo_level[i] + LVL_W'(push[i]) - LVL_W'(pop[i]);
         end
         overflow <= overflow | ovf_set;
         if (fire) begin
            slot.data_out       <= result;
            slot.data_valid_out <= 1'b1;
         end else if (slot.data_ready_in) begin
            slot.data_valid_out <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_grid_slot_nway.sv
// Directed bench for grid_slot_nway: vector table of single-shot operations plus
// hand sequences for latency, backpressure/overflow, config handshake, flush and reset.
module tb_grid_slot_nway;
   import grid_slot_nway_pkg::*;

   localparam int NI = 3;
   localparam int DW = 32;
   localparam int FD = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic cfg_valid = 1'b0;
   logic [2:0] cfg_op = 3'd0;
   logic [NI-1:0] cfg_use_mask = '0;
   logic cfg_use_const = 1'b0;
   logic [DW-1:0] cfg_const = '0;
   logic cfg_ack;
   logic flush = 1'b0;
   logic [NI-1:0][2:0] fifo_level;
   logic [NI-1:0] overflow;

   int total = 0;
   int passed = 0;

   grid_slot_nway_if #(.NUM_INPUTS(NI), .DATA_WIDTH(DW)) bus ();

   grid_slot_nway #(.NUM_INPUTS(NI), .DATA_WIDTH(DW), .FIFO_DEPTH(FD)) dut (
      .clk           (clk),
      .rst           (rst),
      .slot          (bus),
      .cfg_valid     (cfg_valid),
      .cfg_op        (cfg_op),
      .cfg_use_mask  (cfg_use_mask),
      .cfg_use_const (cfg_use_const),
      .cfg_const     (cfg_const),
      .cfg_ack       (cfg_ack),
      .flush         (flush),
      .fifo_level    (fifo_level),
      .overflow      (overflow)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]    op;
      logic [NI-1:0] mask;
      logic          uc;
      logic [DW-1:0] cst;
      logic [DW-1:0] a0, a1, a2;
      logic [DW-1:0] exp;
   } vec_t;

   vec_t vecs[12];

   function automatic vec_t mk(input logic [2:0] op, input logic [NI-1:0] mask,
                               input logic uc, input logic [DW-1:0] cst,
                               input logic [DW-1:0] a0, input logic [DW-1:0] a1,
                               input logic [DW-1:0] a2, input logic [DW-1:0] exp);
      vec_t v;
      v.op = op; v.mask = mask; v.uc = uc; v.cst = cst;
      v.a0 = a0; v.a1 = a1; v.a2 = a2; v.exp = exp;
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got === exp) passed++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
   endtask

   task automatic do_cfg(input logic [2:0] op, input logic [NI-1:0] mask,
                         input logic uc, input logic [DW-1:0] cst);
      logic got;
      got = 1'b0;
      cfg_valid = 1'b1; cfg_op = op; cfg_use_mask = mask;
      cfg_use_const = uc; cfg_const = cst;
      for (int k = 0; k < 20 && !got; k++) begin
         tick();
         if (cfg_ack) got = 1'b1;
      end
      cfg_valid = 1'b0;
      check("cfg_ack_arrives", {63'd0, got}, 64'd1);
   endtask

   task automatic push(input logic [NI-1:0] vld, input logic [DW-1:0] a0,
                       input logic [DW-1:0] a1, input logic [DW-1:0] a2);
      bus.data_in[0] = a0; bus.data_in[1] = a1; bus.data_in[2] = a2;
      bus.data_valid_in = vld;
      tick();
      bus.data_valid_in = '0;
   endtask

   initial begin
      bus.data_in = '0;
      bus.data_valid_in = '0;
      bus.data_ready_in = 1'b1;

      vecs[0]  = mk(OP_ADD,  3'b011, 1'b0, 32'd0,  32'd5,          32'd7,      32'd0,  32'd12);
      vecs[1]  = mk(OP_SUM,  3'b111, 1'b0, 32'd0,  32'hFFFF_FFFF,  32'd1,      32'd2,  32'd2);
      vecs[2]  = mk(OP_SUB,  3'b011, 1'b0, 32'd0,  32'd3,          32'd5,      32'd0,  32'hFFFF_FFFE);
      vecs[3]  = mk(OP_AND,  3'b011, 1'b0, 32'd0,  32'h0000_F0F0,  32'h0000_FF00, 32'd0, 32'h0000_F000);
      vecs[4]  = mk(OP_OR,   3'b011, 1'b0, 32'd0,  32'h0000_F0F0,  32'h0000_0F0F, 32'd0, 32'h0000_FFFF);
      vecs[5]  = mk(OP_XOR,  3'b011, 1'b0, 32'd0,  32'h0000_00FF,  32'h0000_000F, 32'd0, 32'h0000_00F0);
      vecs[6]  = mk(OP_SLL,  3'b001, 1'b1, 32'd4,  32'd1,          32'd99,     32'd0,  32'd16);
      vecs[7]  = mk(OP_PASS, 3'b001, 1'b0, 32'd0,  32'hDEAD_BEEF,  32'd1,      32'd2,  32'hDEAD_BEEF);
      vecs[8]  = mk(OP_ADD,  3'b001, 1'b1, 32'd10, 32'd5,          32'd77,     32'd0,  32'd15);
      vecs[9]  = mk(OP_SLL,  3'b011, 1'b0, 32'd0,  32'd3,          32'd37,     32'd0,  32'd96);
      vecs[10] = mk(OP_SUB,  3'b001, 1'b1, 32'd1,  32'd0,          32'd0,      32'd0,  32'hFFFF_FFFF);
      vecs[11] = mk(OP_SUM,  3'b101, 1'b0, 32'd0,  32'd10,         32'd500,    32'd20, 32'd30);

      // Reset state
      tick(); tick();
      rst = 1'b0;
      check("rst_valid_out", {63'd0, bus.data_valid_out}, 64'd0);
      check("rst_data_out", {32'd0, bus.data_out}, 64'd0);
      check("rst_levels", {55'd0, fifo_level}, 64'd0);
      check("rst_overflow", {61'd0, overflow}, 64'd0);
      check("rst_cfg_ack", {63'd0, cfg_ack}, 64'd0);

      // Inert slot: mask=0 ignores pushes
      push(3'b111, 32'd1, 32'd2, 32'd3);
      check("inert_levels", {55'd0, fifo_level}, 64'd0);
      tick();
      check("inert_no_result", {63'd0, bus.data_valid_out}, 64'd0);

      // Vector table
      for (int v = 0; v < 12; v++) begin
         do_cfg(vecs[v].op, vecs[v].mask, vecs[v].uc, vecs[v].cst);
         push(3'b111, vecs[v].a0, vecs[v].a1, vecs[v].a2);
         tick();
         check($sformatf("vec%0d_valid", v), {63'd0, bus.data_valid_out}, 64'd1);
         check($sformatf("vec%0d_data", v), {32'd0, bus.data_out}, {32'd0, vecs[v].exp});
         check($sformatf("vec%0d_levels", v), {55'd0, fifo_level}, 64'd0);
         check($sformatf("vec%0d_overflow", v), {61'd0, overflow}, 64'd0);
         tick();
         check($sformatf("vec%0d_drained", v), {63'd0, bus.data_valid_out}, 64'd0);
      end

      // Latency: join waits for the later channel, result one edge after it
      do_cfg(OP_ADD, 3'b011, 1'b0, 32'd0);
      push(3'b001, 32'd5, 32'd0, 32'd0);
      tick(); tick();
      check("lat_wait_valid", {63'd0, bus.data_valid_out}, 64'd0);
      check("lat_ch0_level", {61'd0, fifo_level[0]}, 64'd1);
      push(3'b010, 32'd0, 32'd7, 32'd0);
      check("lat_push_edge_valid", {63'd0, bus.data_valid_out}, 64'd0);
      tick();
      check("lat_result_valid", {63'd0, bus.data_valid_out}, 64'd1);
      check("lat_result_data", {32'd0, bus.data_out}, 64'd12);
      tick();
      check("lat_single_result", {63'd0, bus.data_valid_out}, 64'd0);

      // Backpressure: first pair lands in the output, FD fill the FIFOs, last one drops
      bus.data_ready_in = 1'b0;
      for (int k = 0; k < FD + 2; k++) push(3'b011, DW'(k + 1), DW'(100 * (k + 1)), 32'd0);
      tick();
      check("bp_level0", {61'd0, fifo_level[0]}, FD);
      check("bp_level1", {61'd0, fifo_level[1]}, FD);
      check("bp_overflow", {61'd0, overflow}, 64'd3);
      check("bp_hold_valid", {63'd0, bus.data_valid_out}, 64'd1);
      check("bp_hold_data", {32'd0, bus.data_out}, 64'd101);
      // Drain; first drain edge also pushes into the full FIFOs alongside the pop
      bus.data_ready_in = 1'b1;
      push(3'b011, 32'd7, 32'd700, 32'd0);
      check("bp_full_pushpop_level", {61'd0, fifo_level[0]}, FD);
      for (int k = 1; k <= FD; k++) begin
         check($sformatf("bp_drain%0d", k), {32'd0, bus.data_out}, 64'(101 * (k + 1)));
         tick();
      end
      check("bp_drain_last", {32'd0, bus.data_out}, 64'd707);
      tick();
      check("bp_drained_valid", {63'd0, bus.data_valid_out}, 64'd0);
      check("bp_overflow_sticky", {61'd0, overflow}, 64'd3);
      flush = 1'b1; tick(); flush = 1'b0;
      check("flush_clears_overflow", {61'd0, overflow}, 64'd0);
      push(3'b011, 32'd2, 32'd3, 32'd0);
      tick();
      check("flush_keeps_cfg", {32'd0, bus.data_out}, 64'd5);
      tick();

      // Config held off while channel 0 holds data
      push(3'b001, 32'd5, 32'd0, 32'd0);
      cfg_valid = 1'b1; cfg_op = OP_SUB; cfg_use_mask = 3'b011;
      cfg_use_const = 1'b0; cfg_const = '0;
      for (int k = 0; k < 3; k++) begin
         tick();
         check("cfg_pending_no_ack", {63'd0, cfg_ack}, 64'd0);
      end
      push(3'b010, 32'd0, 32'd9, 32'd0);
      check("cfg_push_edge_no_ack", {63'd0, cfg_ack}, 64'd0);
      tick();
      check("cfg_old_op_data", {32'd0, bus.data_out}, 64'd14);
      check("cfg_fire_no_ack", {63'd0, cfg_ack}, 64'd0);
      tick();
      check("cfg_outvalid_no_ack", {63'd0, cfg_ack}, 64'd0);
      tick();
      check("cfg_idle_ack", {63'd0, cfg_ack}, 64'd1);
      cfg_valid = 1'b0;
      push(3'b011, 32'd9, 32'd5, 32'd0);
      check("cfg_ack_pulse", {63'd0, cfg_ack}, 64'd0);
      tick();
      check("cfg_new_op_data", {32'd0, bus.data_out}, 64'd4);
      tick();

      // Flush with config pending: flush wins, config accepted next edge
      push(3'b001, 32'd1, 32'd0, 32'd0);
      cfg_valid = 1'b1; cfg_op = OP_ADD; cfg_use_mask = 3'b011;
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("flushcfg_level0", {61'd0, fifo_level[0]}, 64'd0);
      check("flushcfg_no_ack", {63'd0, cfg_ack}, 64'd0);
      tick();
      check("flushcfg_ack", {63'd0, cfg_ack}, 64'd1);
      cfg_valid = 1'b0;
      tick();

      // Reset with full FIFOs, valid output and overflow
      bus.data_ready_in = 1'b0;
      for (int k = 0; k < FD + 2; k++) push(3'b011, 32'd1, 32'd1, 32'd0);
      check("prerst_valid", {63'd0, bus.data_valid_out}, 64'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("midrst_valid", {63'd0, bus.data_valid_out}, 64'd0);
      check("midrst_data", {32'd0, bus.data_out}, 64'd0);
      check("midrst_levels", {55'd0, fifo_level}, 64'd0);
      check("midrst_overflow", {61'd0, overflow}, 64'd0);
      check("midrst_cfg_ack", {63'd0, cfg_ack}, 64'd0);
      bus.data_ready_in = 1'b1;
      push(3'b111, 32'd4, 32'd5, 32'd6);
      check("postrst_ignored", {55'd0, fifo_level}, 64'd0);
      tick();
      check("postrst_no_result", {63'd0, bus.data_valid_out}, 64'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
